// File: rtl/usb_txn_arbiter.sv
// usb_txn_arbiter: round-robin scheduler in front of the host protocol FSM.
// Grants one requester at a time, issues a one-cycle start, waits for
// system_done (or aborts on timeout), reports done/ok to the owner and keeps
// saturating transaction/failure counters.
//
// Handshake: a request is a level on req[i], sampled only in IDLE. Once
// granted, the transaction runs to completion regardless of req[i]; the owner
// sees exactly one req_done[i] pulse with req_ok qualifying it. Toward the
// protocol FSM, start is a one-cycle pulse, and system_done/process_success
// are honoured only while waiting.
module usb_txn_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 7,
   parameter int ENDP_W  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      rst_l,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_rw,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*ENDP_W-1:0] req_endp,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        req_done,
   output logic                      req_ok,
   output logic                      start,
   output logic                      read_write,
   output logic [ADDR_W-1:0]         addr,
   output logic [ENDP_W-1:0]         endp,
   input  logic                      system_done,
   input  logic                      process_success,
   output logic                      abort,
   output logic [15:0]               txn_count,
   output logic [15:0]               fail_count,
   output logic [1:0]                dbg_state_o
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0]   PTR_INIT = PTR_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      REPORT = 2'd3
   } state_e;

   state_e               state_q;
   logic [PTR_W-1:0]     last_ptr_q;
   logic [PTR_W-1:0]     owner_q;
   logic [TMR_W-1:0]     timer_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic [NUM_REQ-1:0]   req_done_q;
   logic                 req_ok_q;
   logic                 start_q;
   logic                 read_write_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [ENDP_W-1:0]    endp_q;
   logic [15:0]          txn_count_q;
   logic [15:0]          fail_count_q;

   logic                 sel_vld;
   logic [PTR_W-1:0]     sel_idx;
   logic [PTR_W-1:0]     cand_idx;
   logic                 timed_out;

   // Round-robin pick: first set req searching upward from last_ptr+1.
   // Descending offsets so the nearest requester is the last one assigned.
   always_comb begin
      sel_vld  = 1'b0;
      sel_idx  = '0;
      cand_idx = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand_idx = PTR_W'((int'(last_ptr_q) + off) % NUM_REQ);
         if (req[cand_idx]) begin
            sel_vld = 1'b1;
            sel_idx = cand_idx;
         end
      end
   end

   // Timeout fires on the last allowed WAIT cycle unless system_done arrives
   // in that same cycle; completion wins, so abort must see system_done.
   assign timed_out = (state_q == WAIT) && (timer_q == TMR_LAST);
   assign abort     = timed_out && !system_done;

   // Main FSM: arbitration, start pulse, completion/timeout, reporting.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q      <= IDLE;
         last_ptr_q   <= PTR_INIT;
         owner_q      <= '0;
         timer_q      <= '0;
         grant_q      <= '0;
         req_done_q   <= '0;
         req_ok_q     <= 1'b0;
         start_q      <= 1'b0;
         read_write_q <= 1'b0;
         addr_q       <= '0;
         endp_q       <= '0;
         txn_count_q  <= '0;
         fail_count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_vld) begin
                  owner_q      <= sel_idx;
                  grant_q      <= ONE_HOT0 << sel_idx;
                  read_write_q <= req_rw[sel_idx];
                  addr_q       <= req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
                  endp_q       <= req_endp[int'(sel_idx)*ENDP_W +: ENDP_W];
                  start_q      <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               start_q <= 1'b0;
               timer_q <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (system_done) begin
                  req_done_q <= grant_q;
                  req_ok_q   <= process_success;
                  state_q    <= REPORT;
               end else if (timed_out) begin
                  req_done_q <= grant_q;
                  req_ok_q   <= 1'b0;
                  state_q    <= REPORT;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            REPORT: begin
               if (txn_count_q != 16'hFFFF) begin
                  txn_count_q <= txn_count_q + 16'd1;
               end
               if (!req_ok_q && (fail_count_q != 16'hFFFF)) begin
                  fail_count_q <= fail_count_q + 16'd1;
               end
               req_done_q <= '0;
               req_ok_q   <= 1'b0;
               grant_q    <= '0;
               last_ptr_q <= owner_q;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant       = grant_q;
   assign req_done    = req_done_q;
   assign req_ok      = req_ok_q;
   assign start       = start_q;
   assign read_write  = read_write_q;
   assign addr        = addr_q;
   assign endp        = endp_q;
   assign txn_count   = txn_count_q;
   assign fail_count  = fail_count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_usb_txn_arbiter.sv
// Directed bench for usb_txn_arbiter with a short timeout.
module tb_usb_txn_arbiter;

   localparam int NR = 4;
   localparam int AW = 7;
   localparam int EW = 4;
   localparam int TO = 16;

   logic           clk;
   logic           rst_l;
   logic [NR-1:0]  req;
   logic [NR-1:0]  req_rw;
   logic [NR*AW-1:0] req_addr;
   logic [NR*EW-1:0] req_endp;
   logic [NR-1:0]  grant;
   logic [NR-1:0]  req_done;
   logic           req_ok;
   logic           start;
   logic           read_write;
   logic [AW-1:0]  addr;
   logic [EW-1:0]  endp;
   logic           system_done;
   logic           process_success;
   logic           abort;
   logic [15:0]    txn_count;
   logic [15:0]    fail_count;
   logic [1:0]     dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   usb_txn_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .ENDP_W(EW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_l(rst_l), .req(req), .req_rw(req_rw),
      .req_addr(req_addr), .req_endp(req_endp), .grant(grant),
      .req_done(req_done), .req_ok(req_ok), .start(start),
      .read_write(read_write), .addr(addr), .endp(endp),
      .system_done(system_done), .process_success(process_success),
      .abort(abort), .txn_count(txn_count), .fail_count(fail_count),
      .dbg_state_o(dbg_state)
   );

   // clock and global watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic rw, input logic [AW-1:0] a,
                          input logic [EW-1:0] e);
      req_rw[idx]            = rw;
      req_addr[idx*AW +: AW] = a;
      req_endp[idx*EW +: EW] = e;
   endtask

   task automatic do_reset();
      rst_l = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
   endtask

   // Returns at the negedge of the ISSUE cycle, bounded.
   task automatic wait_start(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (start === 1'b1) begin
            seen = 1'b1;
            return;
         end
      end
      chk("start_wait", 32'd0, 32'd1);
   endtask

   // One transaction: system_done driven lat+1 cycles after start.
   // Returns at the negedge of the REPORT cycle.
   task automatic do_txn(input string tag, input logic [NR-1:0] exp_g, input logic ok,
                         input int lat, input bit drop);
      bit seen;
      wait_start(seen);
      if (!seen) return;
      chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
      if (drop) req = '0;
      repeat (lat + 1) @(negedge clk);
      system_done     = 1'b1;
      process_success = ok;
      @(negedge clk);
      system_done     = 1'b0;
      process_success = 1'b0;
      chk({tag, "_done"}, 32'(req_done), 32'(exp_g));
      chk({tag, "_ok"}, 32'(req_ok), 32'(ok));
   endtask

   logic [NR-1:0] rr_exp [5];
   int            hits;
   bit            seen;

   initial begin
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst_l = 1'b0;
      req = '0; req_rw = '0; req_addr = '0; req_endp = '0;
      system_done = 1'b0; process_success = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(req_done), 0);
      chk("rst_ok", 32'(req_ok), 0);
      chk("rst_start", 32'(start), 0);
      chk("rst_abort", 32'(abort), 0);
      chk("rst_rw", 32'(read_write), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_endp", 32'(endp), 0);
      chk("rst_txn", 32'(txn_count), 0);
      chk("rst_fail", 32'(fail_count), 0);
      chk("rst_state", 32'(dbg_state), 0);
      rst_l = 1'b1;
      @(negedge clk);

      // single write
      set_req(0, 1'b1, 7'h05, 4'h2);
      req = 4'b0001;
      @(negedge clk);
      chk("wr_start", 32'(start), 1);
      chk("wr_grant", 32'(grant), 32'h1);
      chk("wr_rw", 32'(read_write), 1);
      chk("wr_addr", 32'(addr), 32'h05);
      chk("wr_endp", 32'(endp), 32'h2);
      req = '0;
      @(negedge clk);
      chk("wr_start_pulse", 32'(start), 0);
      repeat (9) @(negedge clk);
      system_done = 1'b1; process_success = 1'b1;
      @(negedge clk);
      system_done = 1'b0; process_success = 1'b0;
      chk("wr_done", 32'(req_done), 32'h1);
      chk("wr_ok", 32'(req_ok), 1);
      @(negedge clk);
      chk("wr_txn", 32'(txn_count), 1);
      chk("wr_fail", 32'(fail_count), 0);
      chk("wr_done_clr", 32'(req_done), 0);
      chk("wr_grant_clr", 32'(grant), 0);

      // failed read from requester 1
      set_req(1, 1'b0, 7'h11, 4'h3);
      req = 4'b0010;
      do_txn("fail", 4'b0010, 1'b0, 3, 1'b1);
      @(negedge clk);
      chk("fail_txn", 32'(txn_count), 2);
      chk("fail_fail", 32'(fail_count), 1);
      chk("fail_addr_hold", 32'(addr), 32'h11);
      chk("fail_rw_hold", 32'(read_write), 0);

      // round robin from reset with all requesting
      do_reset();
      set_req(2, 1'b1, 7'h22, 4'h4);
      set_req(3, 1'b0, 7'h33, 4'h5);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) do_txn($sformatf("rr%0d", i), rr_exp[i], 1'b1, 0, 1'b0);
      req = '0;
      @(negedge clk);
      chk("rr_txn", 32'(txn_count), 5);
      chk("rr_fail", 32'(fail_count), 0);

      // timeout: requester 2, never complete
      req = 4'b0100;
      wait_start(seen);
      req = '0;
      hits = 0;
      repeat (TO - 1) begin
         @(negedge clk);
         if (abort) hits++;
      end
      chk("to_abort_early", hits, 0);
      @(negedge clk);
      chk("to_abort", 32'(abort), 1);
      chk("to_no_done_yet", 32'(req_done), 0);
      @(negedge clk);
      chk("to_abort_pulse", 32'(abort), 0);
      chk("to_done", 32'(req_done), 32'h4);
      chk("to_ok", 32'(req_ok), 0);
      @(negedge clk);
      chk("to_txn", 32'(txn_count), 6);
      chk("to_fail", 32'(fail_count), 1);

      // system_done on the timeout cycle wins
      req = 4'b0100;
      wait_start(seen);
      req = '0;
      repeat (TO - 1) @(negedge clk);
      @(negedge clk);
      system_done = 1'b1; process_success = 1'b1;
      #1;
      chk("tie_abort", 32'(abort), 0);
      @(negedge clk);
      system_done = 1'b0; process_success = 1'b0;
      chk("tie_done", 32'(req_done), 32'h4);
      chk("tie_ok", 32'(req_ok), 1);
      chk("tie_abort_after", 32'(abort), 0);

      // late drop of req[2], then a stray system_done in IDLE
      req = 4'b0100;
      do_txn("drop", 4'b0100, 1'b1, 2, 1'b1);
      @(negedge clk);
      chk("drop_txn", 32'(txn_count), 8);
      system_done = 1'b1; process_success = 1'b1;
      @(negedge clk);
      system_done = 1'b0; process_success = 1'b0;
      hits = 0;
      repeat (3) begin
         if (req_done != 0 || start || grant != 0) hits++;
         @(negedge clk);
      end
      chk("stray_quiet", hits, 0);
      chk("stray_txn", 32'(txn_count), 8);
      chk("stray_state", 32'(dbg_state), 0);

      // reset while waiting
      req = 4'b0010;
      wait_start(seen);
      chk("rw_grant", 32'(grant), 32'h2);
      req = '0;
      repeat (2) @(negedge clk);
      rst_l = 1'b0;
      #1;
      chk("rw_grant_clr", 32'(grant), 0);
      chk("rw_start", 32'(start), 0);
      chk("rw_txn", 32'(txn_count), 0);
      chk("rw_fail", 32'(fail_count), 0);
      chk("rw_state", 32'(dbg_state), 0);
      hits = 0;
      repeat (2) begin
         @(negedge clk);
         if (req_done != 0) hits++;
      end
      rst_l = 1'b1;
      @(negedge clk);
      if (req_done != 0) hits++;
      chk("rw_no_done", hits, 0);
      req = 4'b0011;
      do_txn("post_rst", 4'b0001, 1'b1, 0, 1'b1);
      @(negedge clk);
      chk("post_rst_txn", 32'(txn_count), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
